// File: rtl/mnk_game_engine.sv
// N x N, K-in-a-row two-player game engine: board registers, turn FSM and a
// sequential win scanner. Optional turn time limit enabled by TURN_TIMEOUT_EN.
module mnk_game_engine #(
    parameter int N           = 3,
    parameter int K           = 3,
    parameter int TIMEOUT_CYC = 1000,
    localparam int CW         = $clog2(N),
    localparam int MCW        = $clog2(N*N+1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               p1,
    input  logic               p2,
    input  logic [CW-1:0]      p1_row,
    input  logic [CW-1:0]      p1_col,
    input  logic [CW-1:0]      p2_row,
    input  logic [CW-1:0]      p2_col,
    output logic [2*N*N-1:0]   board,
    output logic [1:0]         turn,
    output logic               busy,
    output logic               illegal_move,
    output logic [1:0]         winner,
    output logic               draw,
    output logic [MCW-1:0]     move_count,
    output logic               timeout
);
    localparam int IW = $clog2(N*N);
    localparam int SW = $clog2(K+1);

    typedef enum logic [1:0] {WAIT_P1, WAIT_P2, CHECK, DONE} state_t;

    state_t           state_q, state_d;
    logic [1:0]       board_q [N*N];
    logic [1:0]       board_d [N*N];
    logic [MCW-1:0]   move_count_q, move_count_d;
    logic [CW-1:0]    row_q, row_d, col_q, col_d;
    logic [1:0]       player_q, player_d;
    logic [1:0]       dir_q, dir_d;
    logic             neg_q, neg_d;
    logic [SW-1:0]    step_q, step_d, run_q, run_d;
    logic [1:0]       winner_q, winner_d;
    logic             draw_q, draw_d;
    logic             illegal_q, illegal_d;
`ifdef TURN_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC) + 1;
    logic [TW-1:0]    timer_q, timer_d;
    logic             timeout_q, timeout_d;
`endif

    // Request decode: only the player whose turn it is gets looked at.
    logic             req, req_legal;
    logic [CW-1:0]    req_row, req_col;
    logic [1:0]       req_pl;
    logic [IW-1:0]    req_idx;

    always_comb begin
        req     = 1'b0;
        req_row = '0;
        req_col = '0;
        req_pl  = 2'b00;
        if (state_q == WAIT_P1) begin
            req = p1; req_row = p1_row; req_col = p1_col; req_pl = 2'b01;
        end else if (state_q == WAIT_P2) begin
            req = p2; req_row = p2_row; req_col = p2_col; req_pl = 2'b10;
        end
        req_idx   = IW'(int'(req_row) * N + int'(req_col));
        req_legal = (int'(req_row) < N) && (int'(req_col) < N) && (board_q[req_idx] == 2'b00);
    end

    // Scanner probe: cell at distance step_q from the latched stone along the current half-ray.
    int               dr, dc, scan_r, scan_c;
    logic             scan_in, scan_match;
    logic [IW-1:0]    scan_idx;

    always_comb begin
        dr = 0;
        dc = 1;
        case (dir_q)
            2'd0: begin dr = 0; dc = 1;  end
            2'd1: begin dr = 1; dc = 0;  end
            2'd2: begin dr = 1; dc = 1;  end
            default: begin dr = 1; dc = -1; end
        endcase
        if (neg_q) begin
            dr = -dr;
            dc = -dc;
        end
        scan_r     = int'(row_q) + dr * int'(step_q);
        scan_c     = int'(col_q) + dc * int'(step_q);
        scan_in    = (scan_r >= 0) && (scan_r < N) && (scan_c >= 0) && (scan_c < N);
        scan_idx   = IW'(scan_r * N + scan_c);
        scan_match = scan_in && (board_q[scan_idx] == player_q);
    end

    always_comb begin
        state_d      = state_q;
        board_d      = board_q;
        move_count_d = move_count_q;
        row_d        = row_q;
        col_d        = col_q;
        player_d     = player_q;
        dir_d        = dir_q;
        neg_d        = neg_q;
        step_d       = step_q;
        run_d        = run_q;
        winner_d     = winner_q;
        draw_d       = draw_q;
        illegal_d    = 1'b0;
`ifdef TURN_TIMEOUT_EN
        timer_d      = '0;
        timeout_d    = 1'b0;
`endif
        case (state_q)
            WAIT_P1, WAIT_P2: begin
                if (req && req_legal) begin
                    board_d[req_idx] = req_pl;
                    move_count_d     = move_count_q + 1'b1;
                    row_d            = req_row;
                    col_d            = req_col;
                    player_d         = req_pl;
                    dir_d            = 2'd0;
                    neg_d            = 1'b0;
                    step_d           = SW'(1);
                    run_d            = SW'(1);
                    state_d          = CHECK;
                end else if (req) begin
                    illegal_d = 1'b1;
                end
`ifdef TURN_TIMEOUT_EN
                else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    timeout_d = 1'b1;
                    state_d   = (state_q == WAIT_P1) ? WAIT_P2 : WAIT_P1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
`endif
            end
            CHECK: begin
                if (scan_match && (run_q == SW'(K - 1))) begin
                    winner_d = player_q;
                    state_d  = DONE;
                end else begin
                    if (scan_match)
                        run_d = run_q + 1'b1;
                    if (scan_match && (step_q != SW'(K - 1))) begin
                        step_d = step_q + 1'b1;
                    end else begin
                        // Half-ray finished; run carries over into the opposite half.
                        step_d = SW'(1);
                        if (!neg_q) begin
                            neg_d = 1'b1;
                        end else begin
                            neg_d = 1'b0;
                            run_d = SW'(1);
                            if (dir_q != 2'd3) begin
                                dir_d = dir_q + 1'b1;
                            end else if (move_count_q == MCW'(N * N)) begin
                                draw_d  = 1'b1;
                                state_d = DONE;
                            end else begin
                                state_d = (player_q == 2'b01) ? WAIT_P2 : WAIT_P1;
                            end
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= WAIT_P1;
            for (int i = 0; i < N*N; i++) board_q[i] <= 2'b00;
            move_count_q <= '0;
            row_q        <= '0;
            col_q        <= '0;
            player_q     <= 2'b00;
            dir_q        <= 2'd0;
            neg_q        <= 1'b0;
            step_q       <= '0;
            run_q        <= '0;
            winner_q     <= 2'b00;
            draw_q       <= 1'b0;
            illegal_q    <= 1'b0;
`ifdef TURN_TIMEOUT_EN
            timer_q      <= '0;
            timeout_q    <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            board_q      <= board_d;
            move_count_q <= move_count_d;
            row_q        <= row_d;
            col_q        <= col_d;
            player_q     <= player_d;
            dir_q        <= dir_d;
            neg_q        <= neg_d;
            step_q       <= step_d;
            run_q        <= run_d;
            winner_q     <= winner_d;
            draw_q       <= draw_d;
            illegal_q    <= illegal_d;
`ifdef TURN_TIMEOUT_EN
            timer_q      <= timer_d;
            timeout_q    <= timeout_d;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N*N; gi++) begin : g_board
            assign board[2*gi+1:2*gi] = board_q[gi];
        end
    endgenerate

    assign turn         = (state_q == WAIT_P1) ? 2'b01 :
                          (state_q == WAIT_P2) ? 2'b10 : 2'b00;
    assign busy         = (state_q == CHECK);
    assign illegal_move = illegal_q;
    assign winner       = winner_q;
    assign draw         = draw_q;
    assign move_count   = move_count_q;
`ifdef TURN_TIMEOUT_EN
    assign timeout      = timeout_q;
`else
    assign timeout      = 1'b0;
`endif
endmodule
